// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode/funct constants, the reset/flush NOP word
// and the load-use stall FSM state type.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_e;

endpackage

// File: rtl/ifid_hazard_stage_hazard_detect.sv
// Combinational load-use hazard detector: decodes which source registers the
// instruction in IF/ID reads and compares them with the load destination in EX.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       valid,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  output logic       uses_rs,
  output logic       uses_rt,
  output logic       hazard
);

  always_comb begin
    // Jumps and constant shifts do not read rs.
    uses_rs = !((op == OP_J) || (op == OP_JAL) ||
                ((op == OP_RTYPE) &&
                 ((funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA))));
    uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
              (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    hazard  = valid && idex_mem_read && (idex_rt != 5'd0) &&
              ((uses_rs && (idex_rt == rs)) || (uses_rt && (idex_rt == rt)));
  end

endmodule

// File: rtl/ifid_hazard_stage.sv
// IF/ID pipeline register with load-use stall FSM and redirect squash.
// Optional PERF_COUNTERS_EN adds Stall_Cycles / Flush_Count outputs.
module ifid_hazard_stage
  import pipe_pkg::*;
#(
  parameter int          LOAD_USE_STALLS = 1,
  parameter logic [31:0] NOP_WORD        = pipe_pkg::NOP_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction_In,
  input  logic [31:0] PC_Add_In,
  input  logic        IDEX_Mem_Read,
  input  logic [4:0]  IDEX_Rt,
  input  logic        Redirect,
  output logic [31:0] Instruction_Out,
  output logic [31:0] PC_Add_Out,
  output logic        Valid_Out,
  output logic        PC_Write,
  output logic        IDEX_Flush,
  output logic        Stall_Active
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Count
`endif
);

  localparam logic [1:0] CNT_LOAD = 2'(LOAD_USE_STALLS - 1);

  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  stall_state_e state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pc_write, idex_flush;
  logic         uses_rs, uses_rt, hazard;

  hazard_detect u_hazard_detect (
    .op            (instr_q[31:26]),
    .funct         (instr_q[5:0]),
    .rs            (instr_q[25:21]),
    .rt            (instr_q[20:16]),
    .valid         (valid_q),
    .idex_mem_read (IDEX_Mem_Read),
    .idex_rt       (IDEX_Rt),
    .uses_rs       (uses_rs),
    .uses_rt       (uses_rt),
    .hazard        (hazard)
  );

  // Handshake: IF/ID accepts Instruction_In/PC_Add_In on a clock edge exactly
  // when PC_Write=1 and Redirect=0; otherwise it holds (stall) or squashes
  // to NOP (redirect). IDEX_Flush=1 means ID/EX must capture a bubble.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    idex_flush = 1'b0;
    if (Redirect) begin
      instr_d    = NOP_WORD;
      pc_d       = '0;
      valid_d    = 1'b0;
      state_d    = RUN;
      cnt_d      = '0;
      idex_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            pc_write   = 1'b0;
            idex_flush = 1'b1;
            cnt_d      = CNT_LOAD;
            state_d    = (LOAD_USE_STALLS == 2) ? STALL : RUN;
          end else begin
            instr_d = Instruction_In;
            pc_d    = PC_Add_In;
            valid_d = 1'b1;
          end
        end
        STALL: begin
          pc_write   = 1'b0;
          idex_flush = 1'b1;
          // Counter holds the stall cycles still owed, including this one.
          if (cnt_q <= 2'd1) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Instruction_Out = instr_q;
  assign PC_Add_Out      = pc_q;
  assign Valid_Out       = valid_q;
  assign PC_Write        = Rst | pc_write;
  assign IDEX_Flush      = Rst | idex_flush;
  assign Stall_Active    = !Rst && (state_q == STALL);

`ifdef PERF_COUNTERS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, !PC_Write};
    flush_count_d  = flush_count_q + {31'd0, (Redirect && valid_q)};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign Stall_Cycles = stall_cycles_q;
  assign Flush_Count  = flush_count_q;
`endif

endmodule

// File: doc/ifid_hazard_stage.md
Name: ifid_hazard_stage

Overview:
- IF/ID pipeline register combined with load-use hazard control. Sits directly upstream of the ID/EX register.
- Captures the fetched instruction and PC+4 each cycle. Detects load-use dependencies against the instruction in EX, and holds IF/ID and the PC for a programmable number of cycles.
- Drives the ID/EX flush input to insert bubbles. Squashes IF/ID on a taken branch or jump resolved in EX.

Parameters:
- LOAD_USE_STALLS, 1: bubbles inserted per load-use hazard. Legal values are 1 or 2; use 2 for 2-cycle data memory.
- NOP_WORD, 32'h0000_0000: instruction word loaded on reset or flush (sll $0,$0,0).

Ports:
- Clk  in  1  pipeline clock
- Rst  in  1  asynchronous active-high reset
- Instruction_In  in  32  fetched instruction
- PC_Add_In  in  32  PC+4 from fetch
- IDEX_Mem_Read  in  1  Mem_Read_Out of ID/EX (load in EX)
- IDEX_Rt  in  5  Instruction_20_16_Out of ID/EX (load destination)
- Redirect  in  1  taken branch/jump resolved in EX; squash younger instructions
- Instruction_Out  out  32  registered instruction to decode
- PC_Add_Out  out  32  registered PC+4
- Valid_Out  out  1  IF/ID holds a real instruction
- PC_Write  out  1  PC enable to fetch (0 = hold)
- IDEX_Flush  out  1  drives ID/EX flush
- Stall_Active  out  1  FSM in STALL state

Behaviour:
- Reset is asynchronous and active-high. Rst=1 forces Instruction_Out=NOP_WORD, PC_Add_Out=0, Valid_Out=0, FSM=RUN and stall counter=0. While Rst=1: PC_Write=1, IDEX_Flush=1, Stall_Active=0.
- Source decode on Instruction_Out (op=[31:26], funct=[5:0]):
  - uses_rs = !(op==2 || op==3 || (op==0 && funct in {0,2,3}))
  - uses_rt = op==0 || op==4 || op==5 || op in {0x28,0x29,0x2B}
- Hazard is combinational:
  - hazard = Valid_Out && IDEX_Mem_Read && IDEX_Rt!=0 && ((uses_rs && IDEX_Rt==Instruction_Out[25:21]) || (uses_rt && IDEX_Rt==Instruction_Out[20:16])).
- FSM states:
  - RUN:
    - If hazard && !Redirect: PC_Write=0, IF/ID holds, IDEX_Flush=1, counter<=LOAD_USE_STALLS-1.
    - Next state is STALL if LOAD_USE_STALLS==2, else it stays RUN. The hazard has cleared on the next cycle because ID/EX then holds a bubble.
    - Otherwise: PC_Write=1, IF/ID loads inputs with Valid_Out<=1, IDEX_Flush=0.
  - STALL (only reachable with LOAD_USE_STALLS==2):
    - PC_Write=0, IF/ID holds, IDEX_Flush=1, Stall_Active=1.
    - Counter decrements. Exit to RUN when counter==0 at the clock edge. The hazard is not re-evaluated here.
- Redirect has priority over everything, in any state:
  - IF/ID <= NOP_WORD, PC_Add_Out<=0, Valid_Out<=0.
  - IDEX_Flush=1, PC_Write=1, FSM<=RUN, counter<=0.
- Hold means every IF/ID register keeps its value, including Valid_Out.
- Latency: Instruction_In appears on Instruction_Out one cycle after the edge where PC_Write=1 and no Redirect.
- Hazard logic is gated by Valid_Out, so an invalid IF/ID never stalls.
- Rst asserted mid-stall aborts immediately. After release, fetch resumes the cycle after deassertion.
- All outputs are glitch-free functions of registered state plus the ID/EX inputs. There are no combinational paths from Instruction_In to outputs.

Optional Feature:
- PERF_COUNTERS_EN
  - Defined: adds 32-bit output ports Stall_Cycles and Flush_Count, both reset to 0 and wrapping at 2^32.
    - Stall_Cycles increments every cycle PC_Write=0.
    - Flush_Count increments every cycle Redirect=1 && Valid_Out=1.
  - Undefined: the ports and counters are absent, and the block is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW
  - funct constants F_SLL, F_SRL, F_SRA
  - NOP_WORD
  - FSM state enum (RUN, STALL)
- One sub-module, hazard_detect: purely combinational, computing uses_rs, uses_rt and hazard.
- The register and FSM stay in ifid_hazard_stage.

Test Plan:
- Reset: Rst=1 mid-stream -> Instruction_Out=0, PC_Add_Out=0, Valid_Out=0, PC_Write=1. Released, then Instruction_In=32'h012A4020 (add $8,$9,$10), PC_Add_In=4 -> outputs those values next cycle, Valid_Out=1.
- Load-use, rs: IF/ID=32'h01094020 (add $8,$8,$9), IDEX_Mem_Read=1, IDEX_Rt=8 -> one cycle with PC_Write=0, IDEX_Flush=1, IF/ID unchanged. Next cycle IDEX_Mem_Read=0 -> normal advance.
- No false stall: IF/ID=32'h8D090000 (lw $9,0($8)) with IDEX_Rt=9 -> no stall, because rt is not a source. Also IDEX_Rt=0 with any instruction -> no stall.
- LOAD_USE_STALLS=2: IF/ID=32'hAD280004 (sw $8,4($9)), IDEX_Rt=8, load -> exactly two cycles with PC_Write=0, Stall_Active=1 on the second, then resume.
- Redirect during STALL (LOAD_USE_STALLS=2), asserted on the first stall cycle -> IF/ID=NOP, Valid_Out=0, PC_Write=1, FSM=RUN. No further stall cycles.
- PERF_COUNTERS_EN: run the load-use and redirect scenarios -> Stall_Cycles=3, Flush_Count=1.
